// File: rtl/multicycle_control.sv
// Multicycle CPU control sequencer: Moore FSM driving the datapath
// control lines, with memory-ready stalls and a retired-instruction count.
module multicycle_control #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [5:0]           opcode,
   input  logic [5:0]           funct,
   input  logic                 mem_ready,
   output logic                 PCWrite,
   output logic                 PCWriteCond,
   output logic                 IorD,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 IRWrite,
   output logic                 MemtoReg,
   output logic                 ALUSrcA,
   output logic                 RegWrite,
   output logic                 RegDst,
   output logic [1:0]           PCSource,
   output logic [1:0]           ALUSrcB,
   output logic [3:0]           ALUOp,
   output logic [3:0]           state,
   output logic                 halted,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] instr_count
);

   typedef enum logic [3:0] {
      S_INIT, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_READ,
      S_MEM_WB, S_MEM_WRITE, S_R_EXEC, S_R_WB, S_I_EXEC,
      S_I_WB, S_BRANCH, S_JUMP, S_HALT
   } state_t;

   typedef struct packed {
      logic       pcw_j;
      logic       pcwc;
      logic       iord;
      logic       mrd;
      logic       mwr;
      logic       m2r;
      logic       srca;
      logic       rw;
      logic       rdst;
      logic [1:0] pcs;
      logic [1:0] srcb;
      logic [3:0] aop;
      logic       hlt;
   } ctrl_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [3:0] A_ADD = 4'd0;
   localparam logic [3:0] A_SUB = 4'd1;
   localparam logic [3:0] A_AND = 4'd2;
   localparam logic [3:0] A_OR  = 4'd3;
   localparam logic [3:0] A_XOR = 4'd4;
   localparam logic [3:0] A_SLT = 4'd5;

   state_t st, nxt;
   ctrl_t  d, q;
   logic   f_ok, bad, retire;
   logic [3:0] f_op;

   // R-type funct field to ALU operation, with legality
   always_comb begin
      f_ok = 1'b1;
      f_op = A_ADD;
      unique case (funct)
         6'b100000: f_op = A_ADD;
         6'b100010: f_op = A_SUB;
         6'b100100: f_op = A_AND;
         6'b100101: f_op = A_OR;
         6'b100110: f_op = A_XOR;
         6'b101010: f_op = A_SLT;
         default:   f_ok = 1'b0;
      endcase
   end

   // next-state selection and illegal-instruction detection
   always_comb begin
      nxt = st;
      bad = 1'b0;
      unique case (st)
         S_INIT:      nxt = S_FETCH;
         S_FETCH:     if (mem_ready) nxt = S_DECODE;
         S_DECODE: begin
            unique case (opcode)
               OP_R: begin
                  nxt = f_ok ? S_R_EXEC : S_HALT;
                  bad = !f_ok;
               end
               OP_LW, OP_SW:              nxt = S_MEM_ADDR;
               OP_BEQ:                    nxt = S_BRANCH;
               OP_J:                      nxt = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI:  nxt = S_I_EXEC;
               OP_HALT:                   nxt = S_HALT;
               default: begin
                  nxt = S_HALT;
                  bad = 1'b1;
               end
            endcase
         end
         S_MEM_ADDR:  nxt = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  if (mem_ready) nxt = S_MEM_WB;
         S_MEM_WB:    nxt = S_FETCH;
         S_MEM_WRITE: if (mem_ready) nxt = S_FETCH;
         S_R_EXEC:    nxt = S_R_WB;
         S_R_WB:      nxt = S_FETCH;
         S_I_EXEC:    nxt = S_I_WB;
         S_I_WB:      nxt = S_FETCH;
         S_BRANCH:    nxt = S_FETCH;
         S_JUMP:      nxt = S_FETCH;
         S_HALT:      nxt = S_HALT;
         default:     nxt = S_INIT;
      endcase
   end

   assign retire = (nxt == S_FETCH) && (st != S_INIT) && (st != S_FETCH);

   // control word for the state being entered, so outputs come from flops
   always_comb begin
      d = '0;
      unique case (nxt)
         S_FETCH: begin
            d.mrd  = 1'b1;
            d.srcb = 2'b01;
         end
         S_DECODE:   d.srcb = 2'b10;
         S_MEM_ADDR: begin
            d.srca = 1'b1;
            d.srcb = 2'b10;
         end
         S_MEM_READ: begin
            d.mrd  = 1'b1;
            d.iord = 1'b1;
         end
         S_MEM_WB: begin
            d.rw  = 1'b1;
            d.m2r = 1'b1;
         end
         S_MEM_WRITE: begin
            d.mwr  = 1'b1;
            d.iord = 1'b1;
         end
         S_R_EXEC: begin
            d.srca = 1'b1;
            d.aop  = f_op;
         end
         S_R_WB: begin
            d.rw   = 1'b1;
            d.rdst = 1'b1;
         end
         S_I_EXEC: begin
            d.srca = 1'b1;
            if (opcode == OP_ANDI) begin
               d.srcb = 2'b11;
               d.aop  = A_AND;
            end else if (opcode == OP_ORI) begin
               d.srcb = 2'b11;
               d.aop  = A_OR;
            end else begin
               d.srcb = 2'b10;
            end
         end
         S_I_WB:     d.rw = 1'b1;
         S_BRANCH: begin
            d.srca = 1'b1;
            d.aop  = A_SUB;
            d.pcwc = 1'b1;
            d.pcs  = 2'b01;
         end
         S_JUMP: begin
            d.pcw_j = 1'b1;
            d.pcs   = 2'b10;
         end
         S_HALT:     d.hlt = 1'b1;
         default:    d = '0;
      endcase
   end

   // state, registered controls, sticky illegal flag and retire counter
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st          <= S_INIT;
         q           <= '0;
         illegal     <= 1'b0;
         instr_count <= '0;
      end else begin
         st <= nxt;
         q  <= d;
         if (bad) illegal <= 1'b1;
         if (retire)
            instr_count <= instr_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   assign IRWrite     = (st == S_FETCH) && mem_ready;
   assign PCWrite     = q.pcw_j || IRWrite;
   assign PCWriteCond = q.pcwc;
   assign IorD        = q.iord;
   assign MemRead     = q.mrd;
   assign MemWrite    = q.mwr;
   assign MemtoReg    = q.m2r;
   assign ALUSrcA     = q.srca;
   assign RegWrite    = q.rw;
   assign RegDst      = q.rdst;
   assign PCSource    = q.pcs;
   assign ALUSrcB     = q.srcb;
   assign ALUOp       = q.aop;
   assign halted      = q.hlt;
   assign state       = st;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: instruction-path model with a per-cycle
// compare process, plus directed literal checks.
module tb_multicycle_control;

   localparam int CW = 4;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ANDI = 6'b001100;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_HALT = 6'b111111;

   logic clk = 0;
   logic reset = 1;
   logic mem_ready = 1;
   logic [5:0] opcode = OP_R;
   logic [5:0] funct = 6'b100010;

   logic PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic MemtoReg, ALUSrcA, RegWrite, RegDst, halted, illegal;
   logic [1:0] PCSource, ALUSrcB;
   logic [3:0] ALUOp, state;
   logic [CW-1:0] instr_count;
   logic [17:0] dut_ctrl;

   multicycle_control #(.CNT_WIDTH(CW)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
      .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
      .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state), .halted(halted),
      .illegal(illegal), .instr_count(instr_count)
   );

   assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
                      IRWrite, MemtoReg, ALUSrcA, RegWrite, RegDst,
                      PCSource, ALUSrcB, ALUOp};

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- model: each instruction is a list of phases
   int  m_state = 0;
   int  m_cnt = 0;
   bit  m_ill = 0;
   bit  m_pend = 0;
   int  q[$];

   function automatic bit f_legal(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100,
                       6'b100101, 6'b100110, 6'b101010};
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state = 0;
         m_cnt = 0;
         m_ill = 0;
         m_pend = 0;
         q.delete();
      end else begin
         case (m_state)
            0: m_state = 1;
            1: if (mem_ready) begin
               q.delete();
               m_pend = 0;
               case (opcode)
                  OP_R: if (f_legal(funct)) begin
                     q.push_back(7); q.push_back(8);
                  end else begin
                     q.push_back(13); m_pend = 1;
                  end
                  OP_LW: begin
                     q.push_back(3); q.push_back(4); q.push_back(5);
                  end
                  OP_SW: begin
                     q.push_back(3); q.push_back(6);
                  end
                  OP_BEQ: q.push_back(11);
                  OP_J: q.push_back(12);
                  OP_ADDI, OP_ANDI, OP_ORI: begin
                     q.push_back(9); q.push_back(10);
                  end
                  OP_HALT: q.push_back(13);
                  default: begin
                     q.push_back(13); m_pend = 1;
                  end
               endcase
               m_state = 2;
            end
            2: begin
               m_state = q.pop_front();
               if (m_pend) m_ill = 1;
               m_pend = 0;
            end
            13: ;
            default:
               if (!((m_state == 4 || m_state == 6) && !mem_ready)) begin
                  if (q.size() > 0) m_state = q.pop_front();
                  else begin
                     m_state = 1;
                     m_cnt = (m_cnt + 1) % (1 << CW);
                  end
               end
         endcase
      end
   end

   function automatic logic [17:0] exp_ctrl(input int s,
         input logic [5:0] op, input logic [5:0] fn, input logic mr);
      logic pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst;
      logic [1:0] pcs, srcb;
      logic [3:0] aop;
      {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst} = '0;
      pcs = 0; srcb = 0; aop = 0;
      case (s)
         1: begin mrd = 1; srcb = 2'b01; pcw = mr; irw = mr; end
         2: srcb = 2'b10;
         3: begin srca = 1; srcb = 2'b10; end
         4: begin mrd = 1; iord = 1; end
         5: begin rw = 1; m2r = 1; end
         6: begin mwr = 1; iord = 1; end
         7: begin
            srca = 1;
            case (fn)
               6'b100010: aop = 1;
               6'b100100: aop = 2;
               6'b100101: aop = 3;
               6'b100110: aop = 4;
               6'b101010: aop = 5;
               default:   aop = 0;
            endcase
         end
         8: begin rw = 1; rdst = 1; end
         9: begin
            srca = 1;
            if (op == OP_ANDI) begin srcb = 3; aop = 2; end
            else if (op == OP_ORI) begin srcb = 3; aop = 3; end
            else srcb = 2;
         end
         10: rw = 1;
         11: begin srca = 1; aop = 1; pcwc = 1; pcs = 1; end
         12: begin pcw = 1; pcs = 2; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mrd, mwr, irw, m2r, srca, rw, rdst,
              pcs, srcb, aop};
   endfunction

   // compare every cycle on the falling edge
   always @(negedge clk) begin
      chk("state", state, m_state);
      chk("ctrl", dut_ctrl, exp_ctrl(m_state, opcode, funct, mem_ready));
      chk("flags", {halted, illegal}, {m_state == 13, m_ill});
      chk("count", instr_count, m_cnt);
   end

   // ---------------- stimulus
   task automatic do_reset();
      @(posedge clk); #1;
      reset = 0;
      mem_ready = 1;
      #1;
      chk("rst_state", state, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_ill", illegal, 0);
      chk("rst_ctrl", dut_ctrl, 0);
      @(posedge clk); #1;
      reset = 1;
      @(posedge clk); #1;
      chk("init_to_fetch", state, 1);
   endtask

   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
         input int fst, input int mst, output int cycles);
      bit left = 0;
      bit done = 0;
      opcode = op;
      funct = fn;
      cycles = 0;
      for (int c = 0; c < 60 && !done; c++) begin
         if (m_state == 1 && !left && fst > 0) begin
            mem_ready = 0; fst--;
         end else if ((m_state == 4 || m_state == 6) && mst > 0) begin
            mem_ready = 0; mst--;
         end else mem_ready = 1;
         @(posedge clk); #1;
         cycles++;
         if (m_state != 1) left = 1;
         if (left && (m_state == 1 || m_state == 13)) done = 1;
      end
      mem_ready = 1;
      if (!done) chk("instr_timeout", 0, 1);
   endtask

   initial begin
      int cyc;
      do_reset();
      chk("fetch_memread", MemRead, 1);
      chk("fetch_irwrite", IRWrite, 1);
      chk("fetch_pcwrite", PCWrite, 1);
      chk("fetch_srcb", ALUSrcB, 1);

      run_instr(OP_R, 6'b100010, 0, 0, cyc);
      chk("sub_cycles", cyc, 4);
      chk("sub_count", instr_count, 1);
      run_instr(OP_LW, 6'b000000, 0, 3, cyc);
      chk("lw_stall_cycles", cyc, 8);
      run_instr(OP_BEQ, 6'b000000, 0, 0, cyc);
      chk("beq_cycles", cyc, 3);
      run_instr(OP_J, 6'b000000, 0, 0, cyc);
      chk("j_cycles", cyc, 3);
      chk("count_after_j", instr_count, 4);
      run_instr(OP_SW, 6'b000000, 0, 2, cyc);
      chk("sw_stall_cycles", cyc, 6);
      run_instr(OP_ADDI, 6'b000000, 0, 0, cyc);
      chk("addi_cycles", cyc, 4);
      run_instr(OP_ANDI, 6'b000000, 0, 0, cyc);
      run_instr(OP_ORI, 6'b000000, 0, 0, cyc);
      run_instr(OP_R, 6'b100000, 0, 0, cyc);
      run_instr(OP_R, 6'b100100, 0, 0, cyc);
      run_instr(OP_R, 6'b100101, 0, 0, cyc);
      run_instr(OP_R, 6'b100110, 2, 0, cyc);
      chk("xor_fetch_stall", cyc, 6);
      run_instr(OP_R, 6'b101010, 0, 0, cyc);
      chk("count_13", instr_count, 13);

      run_instr(OP_HALT, 6'b000000, 0, 0, cyc);
      chk("halt_cycles", cyc, 2);
      repeat (10) @(posedge clk);
      #1;
      chk("halt_stays", state, 13);
      chk("halt_not_illegal", illegal, 0);
      chk("halt_keeps_count", instr_count, 13);

      do_reset();
      run_instr(6'b010101, 6'b000000, 0, 0, cyc);
      chk("ill_cycles", cyc, 2);
      chk("ill_flag", illegal, 1);
      chk("ill_halted", halted, 1);
      repeat (12) @(posedge clk);
      #1;
      chk("ill_sticky", illegal, 1);
      do_reset();
      chk("ill_cleared_halted", halted, 0);

      run_instr(OP_R, 6'b000001, 0, 0, cyc);
      chk("bad_funct_ill", illegal, 1);
      chk("bad_funct_state", state, 13);
      do_reset();

      for (int i = 0; i < 15; i++) run_instr(OP_ORI, 6'b000000, 0, 0, cyc);
      chk("count_max", instr_count, 15);
      run_instr(OP_ORI, 6'b000000, 0, 0, cyc);
      chk("count_wrap", instr_count, 0);

      opcode = OP_SW;
      funct = 6'b000000;
      mem_ready = 1;
      for (int i = 0; i < 10 && m_state != 6; i++) begin
         @(posedge clk); #1;
      end
      mem_ready = 0;
      @(posedge clk); #1;
      chk("sw_stalled_state", state, 6);
      chk("sw_stalled_memwrite", MemWrite, 1);
      #2 reset = 0;
      #1;
      chk("async_memwrite", MemWrite, 0);
      chk("async_state", state, 0);
      chk("async_iord", IorD, 0);
      @(posedge clk); #1;
      reset = 1;
      mem_ready = 1;
      repeat (3) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
